pulse_generator: RTL and testbench
==================================

Name: pulse_generator

Overview:
- Enable-gated clock divider that emits a single-cycle strobe on `pulse_out` once every `Divisor` enabled clock cycles.
- Used as a tick/baud/timebase source that gates slower logic in the single `clk` domain.
- Has no handshake; free-running whenever `enable` is high.

Parameters:
- Width, 4, bit width of the internal cycle counter; must satisfy 2**Width >= Divisor.
- Divisor, 4, number of enabled cycles per output pulse; legal range 1 .. 2**Width.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
- enable  input  1  count enable; counter advances only on edges where enable=1.
- pulse_out  output  1  registered one-clock-wide strobe.

Behaviour:
- State: counter `cnt[Width-1:0]` and register `pulse_q` driving `pulse_out`. Both are flops updated only on clk rising edge.
- Reset (rst=0 at the edge): cnt <= 0 and pulse_out <= 0. Reset has priority over enable.
- Edge with rst=1 and enable=1:
  - if cnt == Divisor-1: cnt <= 0, pulse_out <= 1;
  - else: cnt <= cnt+1, pulse_out <= 0.
- Edge with rst=1 and enable=0: cnt holds its value, pulse_out <= 0. Partial count is preserved across disable, not cleared.
- Latency: the pulse goes high after the Divisor-th enabled edge following reset or the previous pulse.
  - Example, Divisor=4 with enable held high: pulse high after the 4th, 8th, 12th ... enabled edges.
  - Pulse period is exactly Divisor cycles; duty is 1/Divisor.
- Pulse width is always exactly one clk cycle. It is never stretched, even if enable drops in the following cycle.
- Divisor=1: pulse_out high on every cycle following an enabled edge. The counter stays 0.
- Divisor=2**Width: the counter uses its full range and wraps from all-ones to 0 together with the pulse.
- Reset mid-count: the next pulse again needs a full Divisor enabled edges. An active pulse is cleared at the reset edge.
- Reset asserted on the same edge as a terminal count: reset wins, no pulse.
- Comparison constant `Divisor-1` is truncated/cast to Width bits explicitly. No combinational path from inputs to pulse_out.
- Elaboration check: `$error` if Divisor < 1 or Divisor > 2**Width.

Optional Feature:
- Macro PULSE_GENERATOR_ASSERT_EN.
- When defined, the module compiles concurrent SVA (all disabled while rst=0):
  - cnt never exceeds Divisor-1;
  - pulse_out is never high on two consecutive cycles when Divisor > 1;
  - pulse_out implies the previous edge had enable=1 and cnt == Divisor-1;
  - cnt is stable across a cycle with enable=0.
- When undefined: no assertions; the RTL and ports are identical.

Decomposition:
- Package pulse_generator_pkg holds:
  - function `clog2_min(divisor)` returning the minimum legal Width;
  - localparam default values DEF_WIDTH=4 and DEF_DIVISOR=4.
- One natural sub-module: mod_counter, a parameterised Width/Modulus counter with synchronous active-low reset, enable and a terminal-count output.
  - pulse_generator instantiates it and registers the terminal-count AND enable into pulse_out.

Test Plan:
- Width=4, Divisor=4. Hold rst=0 for 2 edges, then release with enable=0 for 3 edges -> pulse_out stays 0 throughout.
- Enable=1 continuously for 20 edges -> pulse_out high exactly after enabled edges 4, 8, 12, 16, 20, each for 1 cycle. Count of pulses = 5.
- Enable for 2 edges, drop for 5 edges, re-enable -> first pulse after 2 more enabled edges (count preserved), then every 4.
- Enabled run, assert rst=0 for 2 edges just after cnt reaches 2, release -> pulse_out 0 during reset; next pulse after 4 fresh enabled edges.
- Rst=0 on the same edge as terminal count (cnt=3, enable=1) -> no pulse, cnt=0 afterwards.
- Divisor=1 and Divisor=16 builds with enable held high -> pulse every cycle / every 16th cycle respectively. SVA compiled with PULSE_GENERATOR_ASSERT_EN reports no failures.

Source files
------------

// File: rtl/pulse_generator_pkg.sv
// Shared defaults and sizing helper for the pulse_generator timebase.
package pulse_generator_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_DIVISOR = 4;

  // Smallest counter width able to hold Divisor distinct states (never below 1).
  function automatic int clog2_min(input int divisor);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < divisor) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pulse_generator_mod_counter.sv
// Modulo-N up-counter with synchronous active-low reset, count enable and a
// combinational terminal-count flag (high while the count sits at Modulus-1).
module pulse_generator_mod_counter #(
  parameter int Width   = 4,
  parameter int Modulus = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  output logic             o_terminal
);

  localparam logic [Width-1:0] LAST = Width'(Modulus - 1);

  logic [Width-1:0] r_count;
  logic             w_terminal;

  assign w_terminal = (r_count == LAST);
  assign o_terminal = w_terminal;

  // Advance on enabled edges, wrap to zero at the terminal count, hold otherwise.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous, so it is just the first branch.
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (w_terminal) r_count <= '0;
      else            r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_generator.sv
// Enable-gated clock divider: one-cycle strobe on pulse_out every Divisor
// enabled clock edges. Synchronous active-low reset on rst.
// Optional build macro PULSE_GENERATOR_ASSERT_EN compiles internal SVA checks.
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int Width   = DEF_WIDTH,
  parameter int Divisor = DEF_DIVISOR
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic pulse_out
);

  // Reject divisors the counter cannot represent.
  if (Divisor < 1 || Width < clog2_min(Divisor)) begin : g_bad_divisor
    $error("pulse_generator: Divisor=%0d illegal for Width=%0d", Divisor, Width);
  end

  logic w_terminal;
  logic r_pulse;

  pulse_generator_mod_counter #(
    .Width   (Width),
    .Modulus (Divisor)
  ) u_counter (
    .clk        (clk),
    .i_rst_n    (rst),
    .i_enable   (enable),
    .o_terminal (w_terminal)
  );

  // Register terminal-count AND enable so the strobe is exactly one clean cycle.
  always_ff @(posedge clk) begin
    if (!rst) r_pulse <= 1'b0;
    else      r_pulse <= w_terminal & enable;
  end

  assign pulse_out = r_pulse;

`ifdef PULSE_GENERATOR_ASSERT_EN
  localparam logic [Width-1:0] LAST = Width'(Divisor - 1);

  a_cnt_range : assert property (@(posedge clk) disable iff (!rst)
    u_counter.r_count <= LAST);

  if (Divisor > 1) begin : g_no_back_to_back
    a_single_cycle : assert property (@(posedge clk) disable iff (!rst)
      pulse_out |=> !pulse_out);
  end

  a_pulse_cause : assert property (@(posedge clk) disable iff (!rst)
    enable && (u_counter.r_count == LAST) |=> pulse_out);

  a_pulse_origin : assert property (@(posedge clk) disable iff (!rst)
    !(enable && (u_counter.r_count == LAST)) |=> !pulse_out);

  a_hold_when_idle : assert property (@(posedge clk) disable iff (!rst)
    !enable |=> $stable(u_counter.r_count));
`endif

endmodule

// File: tb/tb_pulse_generator.sv
// Self-checking bench for pulse_generator: Divisor 4, 1 and 16 instances
// against an arithmetic model of enabled-edge counts.
module tb_pulse_generator;

  logic clk = 1'b0;
  logic rst;
  logic en4;
  logic enx;
  logic p4, p1, p16;

  int total = 0;
  int bad   = 0;

  // Model: enabled edges since the last reset; a pulse follows every edge that
  // brings the count to a multiple of the divisor.
  int  n4, n1, n16;
  logic exp4, exp1, exp16;
  int  pulses4;

  always #5 clk = ~clk;

  pulse_generator #(.Width(4), .Divisor(4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(en4), .pulse_out(p4));

  pulse_generator #(.Width(4), .Divisor(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enx), .pulse_out(p1));

  pulse_generator #(.Width(4), .Divisor(16)) u_dut16 (
    .clk(clk), .rst(rst), .enable(enx), .pulse_out(p16));

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs, then compare all three outputs.
  task automatic cycle(input logic r, input logic e4, input logic ex);
    rst = r;
    en4 = e4;
    enx = ex;
    @(posedge clk);
    if (!r) begin
      n4 = 0; n1 = 0; n16 = 0;
      exp4 = 1'b0; exp1 = 1'b0; exp16 = 1'b0;
    end else begin
      if (e4) begin n4++; exp4 = (n4 % 4 == 0); end else exp4 = 1'b0;
      if (ex) begin
        n1++;  exp1  = (n1 % 1 == 0);
        n16++; exp16 = (n16 % 16 == 0);
      end else begin
        exp1 = 1'b0; exp16 = 1'b0;
      end
    end
    #1;
    check("div4", p4, exp4);
    check("div1", p1, exp1);
    check("div16", p16, exp16);
    if (p4 === 1'b1) pulses4++;
  endtask

  initial begin
    n4 = 0; n1 = 0; n16 = 0;
    pulses4 = 0;
    rst = 1'b0; en4 = 1'b0; enx = 1'b0;

    // Reset state, then idle with enable low.
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b1);

    // Continuous enable: pulses after edges 4, 8, 12, 16, 20.
    pulses4 = 0;
    repeat (20) cycle(1'b1, 1'b1, 1'b1);
    check_int("div4_pulse_count", pulses4, 5);

    // Partial count survives a disable window.
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 1'b1);
    repeat (10) cycle(1'b1, 1'b1, 1'b1);

    // Reset mid-count (count at 2), then a fresh full period.
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 1'b1, 1'b1);
    repeat (6) cycle(1'b1, 1'b1, 1'b1);

    // Reset on the terminal-count edge suppresses the pulse.
    cycle(1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (4) cycle(1'b1, 1'b1, 1'b1);

    // Randomized enables with occasional resets.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 25) != 0, $urandom % 2 == 0, $urandom % 8 != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
